// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core channel and memory bus signals shared by the arbiter
// master: arbiter side; slave: core pipeline and memory interconnect side.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  INST_RDEN;
   logic [ADDR_WIDTH-1:0] INST_RIADDR;
   logic [ADDR_WIDTH-1:0] INST_ROADDR;
   logic                  INST_RVALID;
   logic [DATA_WIDTH-1:0] INST_RDATA;
   logic                  DATA_RDEN;
   logic [ADDR_WIDTH-1:0] DATA_RIADDR;
   logic [ADDR_WIDTH-1:0] DATA_ROADDR;
   logic                  DATA_RVALID;
   logic [DATA_WIDTH-1:0] DATA_RDATA;
   logic                  DATA_WREN;
   logic [ADDR_WIDTH-1:0] DATA_WADDR;
   logic [DATA_WIDTH-1:0] DATA_WDATA;
   logic                  MEM_WAIT;
   logic                  MEM_REQ;
   logic                  MEM_WE;
   logic [ADDR_WIDTH-1:0] MEM_ADDR;
   logic [DATA_WIDTH-1:0] MEM_WDATA;
   logic                  MEM_GNT;
   logic                  MEM_RVALID;
   logic [DATA_WIDTH-1:0] MEM_RDATA;

   modport master (
      input  INST_RDEN, INST_RIADDR, DATA_RDEN, DATA_RIADDR,
      input  DATA_WREN, DATA_WADDR, DATA_WDATA,
      input  MEM_GNT, MEM_RVALID, MEM_RDATA,
      output INST_ROADDR, INST_RVALID, INST_RDATA,
      output DATA_ROADDR, DATA_RVALID, DATA_RDATA,
      output MEM_WAIT, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
   );

   modport slave (
      output INST_RDEN, INST_RIADDR, DATA_RDEN, DATA_RIADDR,
      output DATA_WREN, DATA_WADDR, DATA_WDATA,
      output MEM_GNT, MEM_RVALID, MEM_RDATA,
      input  INST_ROADDR, INST_RVALID, INST_RDATA,
      input  DATA_ROADDR, DATA_RVALID, DATA_RDATA,
      input  MEM_WAIT, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority batch arbiter of three core channels onto one memory bus
// Requests are captured in IDLE/DONE and served write, data read, instruction read.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic          CLK,
   input  logic          RST,
   mem_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t                r_state;
   logic                  r_pend_w;
   logic                  r_pend_dr;
   logic                  r_pend_ir;
   logic                  r_srv_dr;
   logic                  r_srv_ir;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [ADDR_WIDTH-1:0] r_draddr;
   logic [ADDR_WIDTH-1:0] r_iraddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [ADDR_WIDTH-1:0] r_inst_roaddr;
   logic [ADDR_WIDTH-1:0] r_data_roaddr;
   logic [DATA_WIDTH-1:0] r_inst_rdata;
   logic [DATA_WIDTH-1:0] r_data_rdata;

   logic w_in_req;
   logic w_any_en;
   logic w_rd_done;
   logic w_more_after_rd;

   assign w_in_req  = (r_state == REQ);
   assign w_any_en  = bus.DATA_WREN | bus.DATA_RDEN | bus.INST_RDEN;
   // A read only starts once the write is gone, so the in-flight read is DR if pending, else IR.
   assign w_rd_done = (w_in_req && bus.MEM_GNT && !r_pend_w && bus.MEM_RVALID) ||
                      ((r_state == RESP) && bus.MEM_RVALID);
   assign w_more_after_rd = r_pend_dr & r_pend_ir;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state       <= IDLE;
         r_pend_w      <= 1'b0;
         r_pend_dr     <= 1'b0;
         r_pend_ir     <= 1'b0;
         r_srv_dr      <= 1'b0;
         r_srv_ir      <= 1'b0;
         r_waddr       <= '0;
         r_draddr      <= '0;
         r_iraddr      <= '0;
         r_wdata       <= '0;
         r_inst_roaddr <= '0;
         r_data_roaddr <= '0;
         r_inst_rdata  <= '0;
         r_data_rdata  <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_pend_w  <= bus.DATA_WREN;
               r_pend_dr <= bus.DATA_RDEN;
               r_pend_ir <= bus.INST_RDEN;
               r_waddr   <= bus.DATA_WADDR;
               r_wdata   <= bus.DATA_WDATA;
               r_draddr  <= bus.DATA_RIADDR;
               r_iraddr  <= bus.INST_RIADDR;
               r_srv_dr  <= 1'b0;
               r_srv_ir  <= 1'b0;
               r_state   <= w_any_en ? REQ : IDLE;
            end
            REQ: begin
               if (bus.MEM_GNT) begin
                  if (r_pend_w) begin
                     r_pend_w <= 1'b0;
                     r_state  <= (r_pend_dr | r_pend_ir) ? REQ : DONE;
                  end else if (bus.MEM_RVALID) begin
                     r_state <= w_more_after_rd ? REQ : DONE;
                  end else begin
                     r_state <= RESP;
                  end
               end
            end
            RESP: begin
               if (bus.MEM_RVALID) begin
                  r_state <= w_more_after_rd ? REQ : DONE;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_rd_done) begin
            if (r_pend_dr) begin
               r_pend_dr     <= 1'b0;
               r_srv_dr      <= 1'b1;
               r_data_rdata  <= bus.MEM_RDATA;
               r_data_roaddr <= r_draddr;
            end else begin
               r_pend_ir     <= 1'b0;
               r_srv_ir      <= 1'b1;
               r_inst_rdata  <= bus.MEM_RDATA;
               r_inst_roaddr <= r_iraddr;
            end
         end
      end
   end

   // Bus outputs decode registered state only, so they hold steady while a grant is awaited.
   assign bus.MEM_WAIT    = (r_state == REQ) || (r_state == RESP);
   assign bus.MEM_REQ     = w_in_req;
   assign bus.MEM_WE      = w_in_req & r_pend_w;
   assign bus.MEM_ADDR    = !w_in_req ? '0 :
                            r_pend_w  ? r_waddr :
                            r_pend_dr ? r_draddr : r_iraddr;
   assign bus.MEM_WDATA   = (w_in_req & r_pend_w) ? r_wdata : '0;
   assign bus.INST_RVALID = (r_state == DONE) & r_srv_ir;
   assign bus.DATA_RVALID = (r_state == DONE) & r_srv_dr;
   assign bus.INST_ROADDR = r_inst_roaddr;
   assign bus.INST_RDATA  = r_inst_rdata;
   assign bus.DATA_ROADDR = r_data_roaddr;
   assign bus.DATA_RDATA  = r_data_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a memory responder and batch scoreboard
module tb_mem_arbiter;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } op_t;
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } res_t;

   int checks = 0;
   int errors = 0;
   op_t  exp_ops[$];
   res_t exp_i[$];
   res_t exp_d[$];
   logic [31:0] mem [logic [31:0]];
   logic [31:0] model_mem [logic [31:0]];

   int gnt_delay    = 0;
   int rlat         = 1;
   bit stray_in_req = 1'b0;
   bit stray_once   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mem_init(input logic [31:0] a, input logic [31:0] d);
      mem[a]       = d;
      model_mem[a] = d;
   endtask

   // Memory: grant after gnt_delay REQ cycles, return read data rlat cycles after grant (<0: never).
   initial begin
      int req_cnt;
      int pend_cnt;
      logic [31:0] pend_data;
      req_cnt = 0;
      pend_cnt = 0;
      pend_data = '0;
      bus.MEM_GNT = 1'b0;
      bus.MEM_RVALID = 1'b0;
      bus.MEM_RDATA = '0;
      forever begin
         @(negedge CLK);
         bus.MEM_GNT = 1'b0;
         bus.MEM_RVALID = 1'b0;
         bus.MEM_RDATA = 32'hBAD0BAD0;
         if (RST) begin
            req_cnt = 0;
            pend_cnt = 0;
         end else begin
            if (pend_cnt > 0) begin
               pend_cnt--;
               if (pend_cnt == 0) begin
                  bus.MEM_RVALID = 1'b1;
                  bus.MEM_RDATA = pend_data;
               end
            end
            if (bus.MEM_REQ) begin
               if (req_cnt >= gnt_delay) begin
                  bus.MEM_GNT = 1'b1;
                  req_cnt = 0;
                  if (bus.MEM_WE) begin
                     mem[bus.MEM_ADDR] = bus.MEM_WDATA;
                  end else if (rlat == 0) begin
                     bus.MEM_RVALID = 1'b1;
                     bus.MEM_RDATA = mem[bus.MEM_ADDR];
                  end else if (rlat > 0) begin
                     pend_cnt = rlat;
                     pend_data = mem[bus.MEM_ADDR];
                  end
               end else begin
                  req_cnt++;
                  if (stray_in_req) begin
                     bus.MEM_RVALID = 1'b1;
                     bus.MEM_RDATA = 32'hFFFF0000;
                  end
               end
            end
         end
         if (stray_once) begin
            bus.MEM_RVALID = 1'b1;
            bus.MEM_RDATA = 32'h77777777;
            stray_once = 1'b0;
         end
      end
   end

   // Scoreboard: bus order, result data, and request stability while ungranted.
   initial begin
      bit prev_hold;
      logic prev_we;
      logic [31:0] prev_addr;
      logic [31:0] prev_wdata;
      op_t op;
      res_t r;
      prev_hold = 1'b0;
      prev_we = 1'b0;
      prev_addr = '0;
      prev_wdata = '0;
      forever begin
         @(negedge CLK);
         #1;
         if (RST) begin
            exp_ops.delete();
            exp_i.delete();
            exp_d.delete();
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               chk("hold_req", {bus.MEM_REQ, bus.MEM_WAIT}, 2'b11);
               chk("hold_we", bus.MEM_WE, prev_we);
               chk("hold_addr", bus.MEM_ADDR, prev_addr);
               chk("hold_wdata", bus.MEM_WDATA, prev_wdata);
            end
            if (bus.MEM_REQ && bus.MEM_GNT) begin
               chk("op_expected", exp_ops.size() > 0, 1'b1);
               if (exp_ops.size() > 0) begin
                  op = exp_ops.pop_front();
                  chk("op_we", bus.MEM_WE, op.we);
                  chk("op_addr", bus.MEM_ADDR, op.addr);
                  if (op.we) chk("op_wdata", bus.MEM_WDATA, op.wdata);
               end
            end
            if (bus.INST_RVALID) begin
               chk("inst_expected", exp_i.size() > 0, 1'b1);
               chk("inst_rvalid_no_wait", bus.MEM_WAIT, 1'b0);
               if (exp_i.size() > 0) begin
                  r = exp_i.pop_front();
                  chk("inst_roaddr", bus.INST_ROADDR, r.addr);
                  chk("inst_rdata", bus.INST_RDATA, r.data);
               end
            end
            if (bus.DATA_RVALID) begin
               chk("data_expected", exp_d.size() > 0, 1'b1);
               chk("data_rvalid_no_wait", bus.MEM_WAIT, 1'b0);
               if (exp_d.size() > 0) begin
                  r = exp_d.pop_front();
                  chk("data_roaddr", bus.DATA_ROADDR, r.addr);
                  chk("data_rdata", bus.DATA_RDATA, r.data);
               end
            end
            prev_hold  = bus.MEM_REQ && !bus.MEM_GNT;
            prev_we    = bus.MEM_WE;
            prev_addr  = bus.MEM_ADDR;
            prev_wdata = bus.MEM_WDATA;
         end
      end
   end

   // Called on a capture-cycle negedge; returns at the first negedge of the batch (REQ).
   task automatic start_batch(input bit w, input logic [31:0] wa, input logic [31:0] wd,
                              input bit dr, input logic [31:0] da,
                              input bit ir, input logic [31:0] ia);
      chk("capture_ready", bus.MEM_WAIT, 1'b0);
      bus.DATA_WREN = w;
      bus.DATA_WADDR = wa;
      bus.DATA_WDATA = wd;
      bus.DATA_RDEN = dr;
      bus.DATA_RIADDR = da;
      bus.INST_RDEN = ir;
      bus.INST_RIADDR = ia;
      if (w) begin
         exp_ops.push_back('{1'b1, wa, wd});
         model_mem[wa] = wd;
      end
      if (dr) begin
         exp_ops.push_back('{1'b0, da, 32'h0});
         exp_d.push_back('{da, model_mem[da]});
      end
      if (ir) begin
         exp_ops.push_back('{1'b0, ia, 32'h0});
         exp_i.push_back('{ia, model_mem[ia]});
      end
      @(negedge CLK);
      bus.DATA_WREN = 1'b0;
      bus.DATA_RDEN = 1'b0;
      bus.INST_RDEN = 1'b0;
   endtask

   // Counts MEM_WAIT cycles; returns on the DONE negedge.
   task automatic wait_done(output int n);
      n = 0;
      while (bus.MEM_WAIT && n < 100) begin
         n++;
         @(negedge CLK);
      end
      if (n >= 100) chk("wait_done_timeout", bus.MEM_WAIT, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.INST_RDEN = 1'b0;
      bus.INST_RIADDR = '0;
      bus.DATA_RDEN = 1'b0;
      bus.DATA_RIADDR = '0;
      bus.DATA_WREN = 1'b0;
      bus.DATA_WADDR = '0;
      bus.DATA_WDATA = '0;
      mem_init(32'h100, 32'h00000013);
      mem_init(32'h104, 32'h00A00093);
      mem_init(32'h040, 32'h00000000);
      mem_init(32'h200, 32'h5555AAAA);
      mem_init(32'h080, 32'hCAFEF00D);
      mem_init(32'h300, 32'h11111111);

      repeat (3) @(negedge CLK);
      chk("reset_outputs", {bus.MEM_REQ, bus.MEM_WAIT, bus.INST_RVALID, bus.DATA_RVALID, bus.MEM_WE}, 5'b0);
      chk("reset_mem_addr", bus.MEM_ADDR, 32'h0);
      chk("reset_inst_rdata", bus.INST_RDATA, 32'h0);
      RST = 1'b0;
      @(negedge CLK);

      // Single fetch
      start_batch(0, 0, 0, 0, 0, 1, 32'h100);
      wait_done(n);
      chk("fetch_wait_cycles", n, 2);
      chk("fetch_rvalids", {bus.INST_RVALID, bus.DATA_RVALID}, 2'b10);
      chk("fetch_roaddr", bus.INST_ROADDR, 32'h100);
      chk("fetch_rdata", bus.INST_RDATA, 32'h00000013);

      // Three-way batch, read-after-write to the same address
      start_batch(1, 32'h40, 32'hDEADBEEF, 1, 32'h40, 1, 32'h104);
      wait_done(n);
      chk("three_wait_cycles", n, 5);
      chk("three_rvalids", {bus.INST_RVALID, bus.DATA_RVALID}, 2'b11);
      chk("three_data_rdata", bus.DATA_RDATA, 32'hDEADBEEF);
      chk("three_inst_rdata", bus.INST_RDATA, 32'h00A00093);

      // New batch captured in DONE
      start_batch(1, 32'h104, 32'h12345678, 0, 0, 1, 32'h104);
      wait_done(n);
      chk("b2b_wait_cycles", n, 3);
      chk("b2b_rvalids", {bus.INST_RVALID, bus.DATA_RVALID}, 2'b10);
      chk("b2b_inst_rdata", bus.INST_RDATA, 32'h12345678);
      chk("b2b_data_hold", bus.DATA_RDATA, 32'hDEADBEEF);
      @(negedge CLK);

      // Grant backpressure with stray RVALID while ungranted
      gnt_delay = 5;
      stray_in_req = 1'b1;
      start_batch(0, 0, 0, 1, 32'h200, 0, 0);
      wait_done(n);
      chk("bp_wait_cycles", n, 7);
      chk("bp_data_rdata", bus.DATA_RDATA, 32'h5555AAAA);
      gnt_delay = 0;
      stray_in_req = 1'b0;

      // Zero-latency memory
      rlat = 0;
      start_batch(0, 0, 0, 1, 32'h80, 0, 0);
      wait_done(n);
      chk("zl_wait_cycles", n, 1);
      chk("zl_data_rvalid", bus.DATA_RVALID, 1'b1);
      chk("zl_data_rdata", bus.DATA_RDATA, 32'hCAFEF00D);
      chk("zl_data_roaddr", bus.DATA_ROADDR, 32'h80);

      start_batch(0, 0, 0, 1, 32'h200, 1, 32'h100);
      wait_done(n);
      chk("zl2_wait_cycles", n, 2);
      chk("zl2_rvalids", {bus.INST_RVALID, bus.DATA_RVALID}, 2'b11);
      rlat = 1;

      // Write only: no RVALID
      start_batch(1, 32'h80, 32'h0BADF00D, 0, 0, 0, 0);
      wait_done(n);
      chk("wr_wait_cycles", n, 1);
      chk("wr_rvalids", {bus.INST_RVALID, bus.DATA_RVALID}, 2'b00);
      @(negedge CLK);

      // Idle
      for (int i = 0; i < 10; i++) begin
         chk("idle_outputs", {bus.MEM_REQ, bus.MEM_WAIT, bus.INST_RVALID, bus.DATA_RVALID}, 4'b0);
         @(negedge CLK);
      end

      // Reset in RESP, then a late MEM_RVALID
      rlat = -1;
      start_batch(0, 0, 0, 0, 0, 1, 32'h300);
      @(negedge CLK);
      chk("resp_state", {bus.MEM_WAIT, bus.MEM_REQ}, 2'b10);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_outputs", {bus.MEM_REQ, bus.MEM_WAIT, bus.INST_RVALID}, 3'b000);
      RST = 1'b0;
      rlat = 1;
      @(posedge CLK);
      stray_once = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("post_rst_idle", {bus.MEM_REQ, bus.MEM_WAIT, bus.INST_RVALID, bus.DATA_RVALID}, 4'b0);
      end
      chk("post_rst_inst_rdata", bus.INST_RDATA, 32'h0);

      // Recovery fetch sees the earlier write
      start_batch(0, 0, 0, 0, 0, 1, 32'h104);
      wait_done(n);
      chk("recover_wait_cycles", n, 2);
      chk("recover_inst_rdata", bus.INST_RDATA, 32'h12345678);
      @(negedge CLK);
      @(negedge CLK);

      chk("ops_drained", exp_ops.size(), 0);
      chk("inst_drained", exp_i.size(), 0);
      chk("data_drained", exp_d.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
